// File: rtl/noc_vc_link_scheduler.sv
// Credit-based link scheduler: round-robin over per-VC handshake inputs onto one
// registered flit bus, with optional wormhole locking of the link to one VC per packet.
module noc_vc_link_scheduler #(
    parameter int unsigned FLIT_WIDTH  = 32,
    parameter int unsigned VCHANNELS   = 2,
    parameter int unsigned CREDITS     = 4,
    parameter bit          LOCK_PACKET = 1'b0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [VCHANNELS-1:0][FLIT_WIDTH-1:0] vc_flit,
    input  logic [VCHANNELS-1:0]                 vc_last,
    input  logic [VCHANNELS-1:0]                 vc_valid,
    output logic [VCHANNELS-1:0]                 vc_ready,
    output logic [FLIT_WIDTH-1:0]                link_flit,
    output logic                                 link_last,
    output logic [VCHANNELS-1:0]                 link_valid,
    input  logic [VCHANNELS-1:0]                 credit_in,
    output logic                                 credit_err
);
    localparam int unsigned CW = $clog2(CREDITS + 1);
    localparam int unsigned PW = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;

    typedef enum logic {StUnlocked, StLocked} lock_state_e;

    lock_state_e           lock_q, lock_d;
    logic [PW-1:0]         lock_vc_q, lock_vc_d;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]         credit_q [VCHANNELS];
    logic [CW-1:0]         credit_d [VCHANNELS];
    logic                  err_q, err_d;
    logic [VCHANNELS-1:0]  link_valid_q;
    logic [FLIT_WIDTH-1:0] link_flit_q;
    logic                  link_last_q;

    logic [VCHANNELS-1:0] eligible;
    logic                 grant_found;
    logic [PW-1:0]        grant_idx;
    logic [PW-1:0]        cand_idx;
    logic                 xfer;

    always_comb begin
        for (int v = 0; v < VCHANNELS; v++) begin
            eligible[v] = vc_valid[v] && (credit_q[v] != '0);
        end
    end

    // While locked only the owning VC is considered; otherwise first eligible from the pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        if (LOCK_PACKET && (lock_q == StLocked)) begin
            grant_found = eligible[lock_vc_q];
            grant_idx   = lock_vc_q;
        end else begin
            for (int unsigned i = 0; i < VCHANNELS; i++) begin
                cand_idx = PW'((32'(rr_ptr_q) + i) % VCHANNELS);
                if (!grant_found && eligible[cand_idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand_idx;
                end
            end
        end
    end

    assign xfer = grant_found && !rst;

    always_comb begin
        vc_ready = '0;
        if (xfer) begin
            vc_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_vc_d = lock_vc_q;
        if (xfer) begin
            rr_ptr_d = (grant_idx == PW'(VCHANNELS - 1)) ? '0 : grant_idx + 1'b1;
            if (LOCK_PACKET) begin
                lock_d    = vc_last[grant_idx] ? StUnlocked : StLocked;
                lock_vc_d = grant_idx;
            end
        end
    end

    // A send and a returned credit on the same VC cancel out.
    always_comb begin
        err_d = err_q;
        for (int v = 0; v < VCHANNELS; v++) begin
            credit_d[v] = credit_q[v];
            if (vc_ready[v] && !credit_in[v]) begin
                credit_d[v] = credit_q[v] - 1'b1;
            end else if (!vc_ready[v] && credit_in[v]) begin
                if (credit_q[v] == CW'(CREDITS)) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q    <= StUnlocked;
            lock_vc_q <= '0;
            rr_ptr_q  <= '0;
            err_q     <= 1'b0;
            for (int v = 0; v < VCHANNELS; v++) begin
                credit_q[v] <= CW'(CREDITS);
            end
        end else begin
            lock_q    <= lock_d;
            lock_vc_q <= lock_vc_d;
            rr_ptr_q  <= rr_ptr_d;
            err_q     <= err_d;
            for (int v = 0; v < VCHANNELS; v++) begin
                credit_q[v] <= credit_d[v];
            end
        end
    end

    // Flit and last hold their previous value on idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_valid_q <= '0;
            link_flit_q  <= '0;
            link_last_q  <= 1'b0;
        end else begin
            link_valid_q <= vc_ready;
            if (xfer) begin
                link_flit_q <= vc_flit[grant_idx];
                link_last_q <= vc_last[grant_idx];
            end
        end
    end

    assign link_valid = link_valid_q;
    assign link_flit  = link_flit_q;
    assign link_last  = link_last_q;
    assign credit_err = err_q;

endmodule

// File: tb/tb_noc_vc_link_scheduler.sv
// Bench for noc_vc_link_scheduler: one unlocked and one packet-locking instance share
// stimulus; each link output is scored against a per-instance expected-flit queue.
module tb_noc_vc_link_scheduler;
    localparam int FW = 32;
    localparam int NV = 2;
    localparam int NC = 4;

    typedef struct packed {
        logic [NV-1:0] lv;
        logic [FW-1:0] flit;
        logic          last;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NV-1:0][FW-1:0] vc_flit;
    logic [NV-1:0]         vc_last, vc_valid, credit_in;
    logic [NV-1:0]         a_ready, a_lv, b_ready, b_lv;
    logic [FW-1:0]         a_flit, b_flit;
    logic                  a_last, b_last, a_err, b_err;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int   n_vec = 0;
    int   n_bad = 0;
    bit   mon_a = 1'b0;
    bit   mon_b = 1'b0;

    always #5 clk = ~clk;

    noc_vc_link_scheduler #(
        .FLIT_WIDTH(FW), .VCHANNELS(NV), .CREDITS(NC), .LOCK_PACKET(1'b0)
    ) u_dut_a (
        .clk(clk), .rst(rst), .vc_flit(vc_flit), .vc_last(vc_last), .vc_valid(vc_valid),
        .vc_ready(a_ready), .link_flit(a_flit), .link_last(a_last), .link_valid(a_lv),
        .credit_in(credit_in), .credit_err(a_err)
    );

    noc_vc_link_scheduler #(
        .FLIT_WIDTH(FW), .VCHANNELS(NV), .CREDITS(NC), .LOCK_PACKET(1'b1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .vc_flit(vc_flit), .vc_last(vc_last), .vc_valid(vc_valid),
        .vc_ready(b_ready), .link_flit(b_flit), .link_last(b_last), .link_valid(b_lv),
        .credit_in(credit_in), .credit_err(b_err)
    );

    // Scoreboard: every emitted flit must match the head of the expected queue.
    always @(negedge clk) begin
        if (mon_a && !rst && a_lv != '0) begin
            n_vec++;
            if (q_a.size() == 0) begin
                n_bad++;
                $display("FAIL link_a_unexpected: got lv=%b flit=%h, required no flit", a_lv, a_flit);
            end else begin
                ea = q_a.pop_front();
                if ({a_lv, a_flit, a_last} !== ea) begin
                    n_bad++;
                    $display("FAIL link_a_flit: got lv=%b flit=%h last=%b, required lv=%b flit=%h last=%b",
                             a_lv, a_flit, a_last, ea.lv, ea.flit, ea.last);
                end
            end
        end
        if (mon_b && !rst && b_lv != '0) begin
            n_vec++;
            if (q_b.size() == 0) begin
                n_bad++;
                $display("FAIL link_b_unexpected: got lv=%b flit=%h, required no flit", b_lv, b_flit);
            end else begin
                eb = q_b.pop_front();
                if ({b_lv, b_flit, b_last} !== eb) begin
                    n_bad++;
                    $display("FAIL link_b_flit: got lv=%b flit=%h last=%b, required lv=%b flit=%h last=%b",
                             b_lv, b_flit, b_last, eb.lv, eb.flit, eb.last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        vc_valid  = '0;
        vc_last   = '0;
        vc_flit   = '0;
        credit_in = '0;
        repeat (2) tick();
        rst = 1'b0;
        q_a.delete();
        q_b.delete();
    endtask

    task automatic test_reset();
        mon_a = 1'b1;
        mon_b = 1'b0;
        rst   = 1'b1;
        for (int c = 0; c < 2; c++) begin
            vc_valid  = NV'($urandom);
            vc_last   = NV'($urandom);
            credit_in = NV'($urandom);
            vc_flit   = {$urandom, $urandom};
            @(negedge clk);
            n_vec++;
            if ({a_lv, a_ready, a_err, b_lv, b_ready, b_err} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs: got %b, required all zero",
                         {a_lv, a_ready, a_err, b_lv, b_ready, b_err});
            end
            tick();
        end
        vc_valid  = '0;
        credit_in = '0;
        rst       = 1'b0;
        q_a.delete();
        tick();
        @(negedge clk);
        n_vec++;
        if ({a_lv, a_flit, a_last, a_err} !== '0) begin
            n_bad++;
            $display("FAIL reset_release_idle: got lv=%b flit=%h last=%b err=%b, required zeros",
                     a_lv, a_flit, a_last, a_err);
        end
        tick();
        vc_valid   = 2'b11;
        vc_last    = 2'b11;
        vc_flit[0] = 32'h10;
        vc_flit[1] = 32'h11;
        q_a.push_back('{lv: 2'b01, flit: 32'h10, last: 1'b1});
        @(negedge clk);
        n_vec++;
        if (a_ready !== 2'b01 || b_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL reset_first_grant: got a=%b b=%b, required 01 01", a_ready, b_ready);
        end
        tick();
        vc_valid = '0;
        @(negedge clk);
        #1;
        n_vec++;
        if (q_a.size() != 0) begin
            n_bad++;
            $display("FAIL reset_drain: got %0d pending, required 0", q_a.size());
        end
    endtask

    task automatic test_credit_exhaust();
        int idx = 0;
        do_reset();
        mon_a = 1'b1;
        mon_b = 1'b0;
        for (int i = 0; i < 6; i++) q_a.push_back('{lv: 2'b01, flit: 32'hA0 + i, last: 1'b1});
        vc_last = 2'b11;
        for (int k = 0; k < 6; k++) begin
            vc_valid   = {1'b0, idx < 6};
            vc_flit[0] = 32'hA0 + idx;
            @(negedge clk);
            n_vec++;
            if (a_ready !== ((k < 4) ? 2'b01 : 2'b00)) begin
                n_bad++;
                $display("FAIL credit_ready_k%0d: got %b, required %b", k, a_ready,
                         (k < 4) ? 2'b01 : 2'b00);
            end
            if (vc_valid[0] && a_ready[0]) idx++;
            tick();
        end
        credit_in  = 2'b01;
        vc_flit[0] = 32'hA0 + idx;
        @(negedge clk);
        n_vec++;
        if (a_ready !== 2'b00 || a_lv !== 2'b00) begin
            n_bad++;
            $display("FAIL credit_stall: got ready=%b lv=%b, required 00 00", a_ready, a_lv);
        end
        tick();
        credit_in = 2'b00;
        @(negedge clk);
        n_vec++;
        if (a_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL credit_return_ready: got %b, required 01", a_ready);
        end
        if (a_ready[0]) idx++;
        tick();
        vc_flit[0] = 32'hA0 + idx;
        @(negedge clk);
        n_vec++;
        if (a_lv !== 2'b01 || a_flit !== 32'hA4 || a_ready !== 2'b00) begin
            n_bad++;
            $display("FAIL credit_a4: got lv=%b flit=%h ready=%b, required 01 000000a4 00",
                     a_lv, a_flit, a_ready);
        end
        tick();
        credit_in = 2'b01;
        tick();
        credit_in = 2'b00;
        for (int k = 0; k < 4; k++) begin
            vc_valid   = {1'b0, idx < 6};
            vc_flit[0] = 32'hA0 + idx;
            @(negedge clk);
            if (vc_valid[0] && a_ready[0]) idx++;
            tick();
        end
        vc_valid = '0;
        tick();
        @(negedge clk);
        #1;
        n_vec++;
        if (q_a.size() != 0) begin
            n_bad++;
            $display("FAIL credit_drain: got %0d pending, required 0", q_a.size());
        end
    endtask

    task automatic test_interleave();
        localparam int N = 5;
        int            i0 = 0, i1 = 0;
        logic [1:0]    h1 = '0, h2 = '0, hs, ex;
        do_reset();
        mon_a = 1'b1;
        mon_b = 1'b0;
        for (int i = 0; i < N; i++) begin
            q_a.push_back('{lv: 2'b01, flit: 32'hB0 + i, last: 1'b1});
            q_a.push_back('{lv: 2'b10, flit: 32'hC0 + i, last: 1'b1});
        end
        vc_last = 2'b11;
        for (int k = 0; k < 2 * N; k++) begin
            credit_in  = h2;
            vc_valid   = {i1 < N, i0 < N};
            vc_flit[0] = 32'hB0 + i0;
            vc_flit[1] = 32'hC0 + i1;
            ex         = (k % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            n_vec++;
            if (a_ready !== ex) begin
                n_bad++;
                $display("FAIL rr_ready_k%0d: got %b, required %b", k, a_ready, ex);
            end
            if (k > 0) begin
                n_vec++;
                if (a_lv !== ~ex) begin
                    n_bad++;
                    $display("FAIL rr_link_k%0d: got %b, required %b", k, a_lv, ~ex);
                end
            end
            hs = vc_valid & a_ready;
            if (hs[0]) i0++;
            if (hs[1]) i1++;
            tick();
            h2 = h1;
            h1 = hs;
        end
        credit_in = h2;
        vc_valid  = '0;
        @(negedge clk);
        #1;
        n_vec++;
        if (q_a.size() != 0) begin
            n_bad++;
            $display("FAIL rr_drain: got %0d pending, required 0", q_a.size());
        end
        tick();
        credit_in = '0;
    endtask

    task automatic test_packet_lock();
        logic [FW-1:0] p0 [6];
        logic          l0 [6];
        logic [1:0]    er [10];
        int            i0 = 0, i1 = 0, j;
        logic [1:0]    h1 = '0, h2 = '0, hs;
        p0 = '{32'hE0, 32'hE1, 32'hE2, 32'hF0, 32'hF1, 32'hF2};
        l0 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        er = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
        do_reset();
        mon_a = 1'b0;
        mon_b = 1'b1;
        for (int i = 0; i < 3; i++) q_b.push_back('{lv: 2'b01, flit: p0[i], last: l0[i]});
        q_b.push_back('{lv: 2'b10, flit: 32'hD0, last: 1'b1});
        for (int i = 3; i < 6; i++) q_b.push_back('{lv: 2'b01, flit: p0[i], last: l0[i]});
        q_b.push_back('{lv: 2'b10, flit: 32'hD1, last: 1'b1});
        for (int k = 0; k < 10; k++) begin
            j           = (i0 < 6) ? i0 : 5;
            credit_in   = h2;
            vc_valid[0] = (i0 < 6) && !(k == 5 || k == 6);
            vc_valid[1] = (i1 < 2);
            vc_flit[0]  = p0[j];
            vc_last[0]  = l0[j];
            vc_flit[1]  = 32'hD0 + i1;
            vc_last[1]  = 1'b1;
            @(negedge clk);
            n_vec++;
            if (b_ready !== er[k]) begin
                n_bad++;
                $display("FAIL lock_ready_k%0d: got %b, required %b", k, b_ready, er[k]);
            end
            if (k > 0) begin
                n_vec++;
                if (b_lv !== er[k-1]) begin
                    n_bad++;
                    $display("FAIL lock_link_k%0d: got %b, required %b", k, b_lv, er[k-1]);
                end
            end
            hs = vc_valid & b_ready;
            if (hs[0]) i0++;
            if (hs[1]) i1++;
            tick();
            h2 = h1;
            h1 = hs;
        end
        vc_valid  = '0;
        credit_in = '0;
        @(negedge clk);
        #1;
        n_vec++;
        if (q_b.size() != 0) begin
            n_bad++;
            $display("FAIL lock_drain: got %0d pending, required 0", q_b.size());
        end
        tick();
    endtask

    task automatic test_simultaneous();
        int i1 = 0;
        do_reset();
        mon_a = 1'b1;
        mon_b = 1'b0;
        for (int i = 0; i < 5; i++) q_a.push_back('{lv: 2'b10, flit: 32'h60 + i, last: 1'b1});
        vc_last = 2'b11;
        for (int k = 0; k < 6; k++) begin
            credit_in  = (k == 3) ? 2'b10 : 2'b00;
            vc_valid   = {i1 < 6, 1'b0};
            vc_flit[1] = 32'h60 + i1;
            @(negedge clk);
            n_vec++;
            if (a_ready !== ((k < 5) ? 2'b10 : 2'b00)) begin
                n_bad++;
                $display("FAIL simul_ready_k%0d: got %b, required %b", k, a_ready,
                         (k < 5) ? 2'b10 : 2'b00);
            end
            if (vc_valid[1] && a_ready[1]) i1++;
            tick();
        end
        vc_valid  = '0;
        credit_in = '0;
        tick();
        @(negedge clk);
        #1;
        n_vec++;
        if (q_a.size() != 0 || a_err !== 1'b0) begin
            n_bad++;
            $display("FAIL simul_drain: got pending=%0d err=%b, required 0 0", q_a.size(), a_err);
        end
    endtask

    task automatic test_overflow();
        int idx = 0;
        do_reset();
        mon_a = 1'b1;
        mon_b = 1'b0;
        credit_in = 2'b01;
        @(negedge clk);
        n_vec++;
        if (a_err !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_before: got %b, required 0", a_err);
        end
        tick();
        credit_in = 2'b00;
        @(negedge clk);
        n_vec++;
        if (a_err !== 1'b1 || b_err !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_set: got a=%b b=%b, required 1 1", a_err, b_err);
        end
        for (int i = 0; i < 4; i++) q_a.push_back('{lv: 2'b01, flit: 32'h70 + i, last: 1'b1});
        vc_last = 2'b11;
        tick();
        for (int k = 0; k < 5; k++) begin
            vc_valid   = 2'b01;
            vc_flit[0] = 32'h70 + idx;
            @(negedge clk);
            n_vec++;
            if (a_ready !== ((k < 4) ? 2'b01 : 2'b00)) begin
                n_bad++;
                $display("FAIL ovf_credit_k%0d: got %b, required %b", k, a_ready,
                         (k < 4) ? 2'b01 : 2'b00);
            end
            if (a_ready[0]) idx++;
            tick();
        end
        vc_valid = '0;
        @(negedge clk);
        #1;
        n_vec++;
        if (a_err !== 1'b1 || q_a.size() != 0) begin
            n_bad++;
            $display("FAIL ovf_sticky: got err=%b pending=%0d, required 1 0", a_err, q_a.size());
        end
        tick();
        do_reset();
        @(negedge clk);
        n_vec++;
        if (a_err !== 1'b0 || b_err !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clear: got a=%b b=%b, required 0 0", a_err, b_err);
        end
        tick();
    endtask

    initial begin
        rst       = 1'b0;
        vc_valid  = '0;
        vc_last   = '0;
        vc_flit   = '0;
        credit_in = '0;
        #1;
        rst = 1'b1;
        test_reset();
        test_credit_exhaust();
        test_interleave();
        test_packet_lock();
        test_simultaneous();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule
